// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bundle: icache/MMU request port, CSR/EXE redirect inputs and the
// IF/ID queue head. The master side is the fetch stage; the slave side is the
// environment around it (icache, CSR, EXE and decode).
interface fetch_prefetch_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                       ic_req_o;
  logic [XLEN-1:0]            ic_addr_o;
  logic                       ic_ack_i;
  logic [31:0]                ic_data_i;
  logic                       ic_fault_i;
  logic                       csr_redirect_i;
  logic [XLEN-1:0]            csr_pc_i;
  logic                       exe_redirect_i;
  logic [XLEN-1:0]            exe_pc_i;
  logic                       id_valid_o;
  logic                       id_ready_i;
  logic [31:0]                id_instr_o;
  logic [XLEN-1:0]            id_pc_o;
  logic [1:0]                 id_exc_o;
  logic [$clog2(DEPTH):0]     fifo_count_o;

  modport master (
    output ic_req_o, ic_addr_o, id_valid_o, id_instr_o, id_pc_o, id_exc_o, fifo_count_o,
    input  ic_ack_i, ic_data_i, ic_fault_i, csr_redirect_i, csr_pc_i,
           exe_redirect_i, exe_pc_i, id_ready_i
  );

  modport slave (
    input  ic_req_o, ic_addr_o, id_valid_o, id_instr_o, id_pc_o, id_exc_o, fifo_count_o,
    output ic_ack_i, ic_data_i, ic_fault_i, csr_redirect_i, csr_pc_i,
           exe_redirect_i, exe_pc_i, id_ready_i
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: one icache request in flight, DEPTH-entry queue
// towards decode, redirect flush with kill of the in-flight response, and
// precise misaligned/fault entries that halt fetch until the next redirect.
module fetch_prefetch #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] pc_ff;
  logic [XLEN-1:0] addr_ff;
  logic            req_ff;
  logic            kill_ff;
  logic            halt_ff;

  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [1:0]      q_exc   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            ack;
  logic            slot_free;
  logic            ack_take;
  logic            mis_push;
  logic            push;
  logic            pop;
  logic [31:0]     push_instr;
  logic [1:0]      push_exc;
  logic [CW-1:0]   count_next;
  logic [XLEN-1:0] pc_next;
  logic            halt_next;
  logic            kill_next;
  logic            new_req;
  logic            req_next;

  // Next-state decode: redirect priority, ack/kill filtering, push/pop and issue rule.
  always_comb begin
    redirect    = bus.csr_redirect_i | bus.exe_redirect_i;
    redirect_pc = bus.csr_redirect_i ? bus.csr_pc_i : bus.exe_pc_i;
    ack         = req_ff & bus.ic_ack_i;
    slot_free   = ~req_ff | bus.ic_ack_i;
    // A killed or redirect-coincident response never reaches the queue.
    ack_take    = ack & ~kill_ff & ~redirect;
    // pc_ff can only be misaligned after a redirect, so this never collides with ack_take.
    mis_push    = ~redirect & (pc_ff[1:0] != 2'b00) & ~halt_ff & slot_free & (count < DEPTH_C);
    push        = ack_take | mis_push;
    pop         = (count != '0) & bus.id_ready_i & ~redirect;

    push_instr  = bus.ic_data_i;
    push_exc    = 2'd0;
    if (mis_push) begin
      push_instr = NOP_INSTR;
      push_exc   = 2'd1;
    end else if (bus.ic_fault_i) begin
      push_instr = NOP_INSTR;
      push_exc   = 2'd2;
    end

    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end

    pc_next = pc_ff;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (ack_take && !bus.ic_fault_i) begin
      pc_next = pc_ff + XLEN'(4);
    end

    halt_next = redirect ? 1'b0 : (halt_ff | (ack_take & bus.ic_fault_i) | mis_push);

    kill_next = kill_ff;
    if (redirect) begin
      kill_next = req_ff & ~bus.ic_ack_i;
    end else if (ack) begin
      kill_next = 1'b0;
    end

    // halt_next (not halt_ff) so a faulting ack does not re-issue the same PC.
    new_req  = slot_free & ~halt_next & (pc_next[1:0] == 2'b00) & (count_next < DEPTH_C);
    req_next = (req_ff & ~bus.ic_ack_i) | new_req;
  end

  // Control registers; the request address is captured only when a new request starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ff   <= RESET_PC;
      addr_ff <= RESET_PC;
      req_ff  <= 1'b0;
      kill_ff <= 1'b0;
      halt_ff <= 1'b0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      pc_ff   <= pc_next;
      req_ff  <= req_next;
      kill_ff <= kill_next;
      halt_ff <= halt_next;
      count   <= count_next;
      if (new_req) begin
        addr_ff <= pc_next;
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
        q_exc[i]   <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]    <= pc_ff;
      q_instr[wr_ptr] <= push_instr;
      q_exc[wr_ptr]   <= push_exc;
    end
  end

  assign bus.ic_req_o     = req_ff;
  assign bus.ic_addr_o    = addr_ff;
  assign bus.id_valid_o   = (count != '0);
  assign bus.id_instr_o   = q_instr[rd_ptr];
  assign bus.id_pc_o      = q_pc[rd_ptr];
  assign bus.id_exc_o     = q_exc[rd_ptr];
  assign bus.fifo_count_o = count;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: icache responder with programmable latency
// and fault address, scoreboard of expected queue entries checked at each pop.
module tb_fetch_prefetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  exc;
  } ent_t;

  logic clk;
  logic rst_n;
  fetch_prefetch_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  int          n_req;
  int          n0;
  int          lat;
  int          wait_cnt;
  logic        in_flight;
  logic        killed;
  logic        last_sighted;
  logic        spurious;
  logic [31:0] cur_addr;
  logic [31:0] next_exp;
  logic [31:0] fault_addr;
  ent_t        sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    in_flight = 1'b0;
    killed    = 1'b0;
    sb.delete();
    next_exp  = RST_PC;
  endtask

  // One clock: called at a falling edge with redirect/ready already driven.
  task automatic cycle();
    logic        redir;
    logic        flt;
    logic [31:0] data;
    ent_t        e;
    redir = bus.csr_redirect_i | bus.exe_redirect_i;
    last_sighted   = 1'b0;
    bus.ic_ack_i   = 1'b0;
    bus.ic_fault_i = 1'b0;
    bus.ic_data_i  = $urandom;
    if (bus.ic_req_o) begin
      if (!in_flight) begin
        in_flight    = 1'b1;
        last_sighted = 1'b1;
        wait_cnt     = lat;
        cur_addr     = next_exp;
        next_exp     = next_exp + 32'd4;
        n_req++;
        chk("req_addr", bus.ic_addr_o, cur_addr);
      end else begin
        chk("addr_hold", bus.ic_addr_o, cur_addr);
      end
      if (wait_cnt == 0) begin
        flt  = (cur_addr == fault_addr);
        data = cur_addr ^ 32'h1357_0a13;
        bus.ic_ack_i   = 1'b1;
        bus.ic_fault_i = flt;
        bus.ic_data_i  = data;
        if (!killed && !redir) begin
          sb.push_back('{pc: cur_addr, instr: (flt ? NOP : data), exc: (flt ? 2'd2 : 2'd0)});
        end
        in_flight = 1'b0;
        killed    = 1'b0;
      end else begin
        wait_cnt--;
        if (redir) killed = 1'b1;
      end
    end else if (spurious) begin
      bus.ic_ack_i   = 1'b1;
      bus.ic_fault_i = 1'($urandom);
    end
    if (redir) begin
      next_exp = bus.csr_redirect_i ? bus.csr_pc_i : bus.exe_pc_i;
      sb.delete();
    end else if (bus.id_valid_o && bus.id_ready_i) begin
      chk("sb_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("id_pc", bus.id_pc_o, e.pc);
        chk("id_instr", bus.id_instr_o, e.instr);
        chk("id_exc", 32'(bus.id_exc_o), 32'(e.exc));
      end
    end
    @(negedge clk);
  endtask

  task automatic redirect(input logic csr, input logic [31:0] cpc, input logic exe, input logic [31:0] epc);
    bus.csr_redirect_i = csr;
    bus.csr_pc_i       = cpc;
    bus.exe_redirect_i = exe;
    bus.exe_pc_i       = epc;
    cycle();
    bus.csr_redirect_i = 1'b0;
    bus.exe_redirect_i = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_req = 0; lat = 0; wait_cnt = 0;
    spurious = 1'b0; fault_addr = 32'h1; last_sighted = 1'b0;
    model_reset();
    rst_n = 1'b0;
    bus.ic_ack_i = 1'b0; bus.ic_data_i = '0; bus.ic_fault_i = 1'b0;
    bus.csr_redirect_i = 1'b0; bus.csr_pc_i = '0;
    bus.exe_redirect_i = 1'b0; bus.exe_pc_i = '0;
    bus.id_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);

    // reset values
    chk("rst_req", 32'(bus.ic_req_o), 32'd0);
    chk("rst_addr", bus.ic_addr_o, RST_PC);
    chk("rst_valid", 32'(bus.id_valid_o), 32'd0);
    chk("rst_instr", bus.id_instr_o, 32'd0);
    chk("rst_pc", bus.id_pc_o, 32'd0);
    chk("rst_exc", 32'(bus.id_exc_o), 32'd0);
    chk("rst_count", 32'(bus.fifo_count_o), 32'd0);

    // streaming, same-cycle ack
    rst_n = 1'b1;
    bus.id_ready_i = 1'b1;
    cycle();
    chk("first_req", 32'(bus.ic_req_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("stream_count", 32'(bus.fifo_count_o <= 3'd1), 32'd1);
    end

    // decode stall fills the queue, then drains in order
    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    chk("full_count", 32'(bus.fifo_count_o), 32'd4);
    chk("full_req", 32'(bus.ic_req_o), 32'd0);
    bus.id_ready_i = 1'b1;
    cycle();
    chk("resume_req", 32'(bus.ic_req_o), 32'd1);
    for (int i = 0; i < 8; i++) cycle();

    // latency 3, EXE redirect one cycle after the request kills its response
    lat = 3;
    last_sighted = 1'b0;
    for (int k = 0; k < 20 && !last_sighted; k++) cycle();
    chk("lat3_sighted", 32'(last_sighted), 32'd1);
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0040);
    chk("kill_flush_valid", 32'(bus.id_valid_o), 32'd0);
    chk("kill_flush_count", 32'(bus.fifo_count_o), 32'd0);
    chk("kill_hold_req", 32'(bus.ic_req_o), 32'd1);
    cycle();
    cycle();
    chk("killed_no_push", 32'(bus.fifo_count_o), 32'd0);
    cycle();
    chk("after_kill_issue", 32'(last_sighted), 32'd1);
    lat = 0;
    for (int i = 0; i < 8; i++) cycle();

    // simultaneous CSR and EXE redirect: CSR wins
    redirect(1'b1, 32'h8000_0100, 1'b1, 32'h8000_0040);
    chk("dual_flush_valid", 32'(bus.id_valid_o), 32'd0);
    chk("dual_flush_count", 32'(bus.fifo_count_o), 32'd0);
    cycle();
    chk("dual_issue", 32'(last_sighted), 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // misaligned target: one exception entry, no request, fetch halted
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0042);
    n0 = n_req;
    sb.push_back('{pc: 32'h8000_0042, instr: NOP, exc: 2'd1});
    for (int i = 0; i < 6; i++) cycle();
    chk("mis_no_req", 32'(n_req - n0), 32'd0);
    chk("mis_popped", 32'(sb.size()), 32'd0);
    chk("mis_halt_req", 32'(bus.ic_req_o), 32'd0);
    chk("mis_count", 32'(bus.fifo_count_o), 32'd0);
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0080);
    cycle();
    chk("mis_resume", 32'(last_sighted), 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // fetch fault at 8000_0008 halts until a CSR redirect
    fault_addr = 32'h8000_0008;
    bus.id_ready_i = 1'b0;
    redirect(1'b1, RST_PC, 1'b0, 32'h0);
    n0 = n_req;
    for (int i = 0; i < 8; i++) cycle();
    chk("fault_reqs", 32'(n_req - n0), 32'd3);
    chk("fault_count", 32'(bus.fifo_count_o), 32'd3);
    chk("fault_req_low", 32'(bus.ic_req_o), 32'd0);
    chk("fault_head_pc", bus.id_pc_o, RST_PC);
    spurious = 1'b1;
    bus.id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    spurious = 1'b0;
    chk("fault_drained", 32'(sb.size()), 32'd0);
    chk("fault_empty", 32'(bus.fifo_count_o), 32'd0);
    chk("fault_still_halt", 32'(bus.ic_req_o), 32'd0);
    redirect(1'b1, 32'h8000_0200, 1'b0, 32'h0);
    cycle();
    chk("fault_resume", 32'(last_sighted), 32'd1);
    bus.id_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    bus.ic_ack_i = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.ic_req_o), 32'd0);
    chk("mid_rst_addr", bus.ic_addr_o, RST_PC);
    chk("mid_rst_count", 32'(bus.fifo_count_o), 32'd0);
    chk("mid_rst_valid", 32'(bus.id_valid_o), 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus.id_ready_i = 1'b1;
    cycle();
    cycle();
    chk("restart_issue", 32'(last_sighted), 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
